// File: rtl/issue_ctrl.sv
// issue_ctrl: single-issue decode/issue sequencer with a RAW/WAW scoreboard,
// registered issue slot and branch/WFI/trap serialisation.
module issue_ctrl #(
    parameter int NREGS     = 32,
    parameter bit ALLOW_WAW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr_i,
    input  logic        instr_vld_i,
    output logic        instr_rdy_o,
    input  logic        dec_vld_i,
    input  logic        dec_rd_vld_i,
    input  logic        dec_rs1_vld_i,
    input  logic        dec_rs2_vld_i,
    input  logic        dec_is_branch_i,
    input  logic        dec_is_jal_i,
    input  logic        dec_is_wfi_i,
    input  logic [3:0]  dec_imm_i,
    input  logic [3:0]  dec_aluop_i,
    input  logic        wb_vld_i,
    input  logic [4:0]  wb_rd_i,
    input  logic        br_done_i,
    input  logic        flush_i,
    input  logic        irq_i,
    output logic        iss_vld_o,
    input  logic        iss_rdy_i,
    output logic [31:0] iss_instr_o,
    output logic [3:0]  iss_aluop_o,
    output logic [3:0]  iss_imm_o,
    output logic        iss_rd_vld_o,
    output logic        iss_is_branch_o,
    output logic        iss_is_jal_o,
    output logic        illegal_o,
    output logic [1:0]  state_o
);
    typedef enum logic [1:0] {RUN, BR_WAIT, WFI, TRAP} state_t;

    state_t           state, state_n;
    logic [NREGS-1:1] sb, sb_eff, sb_n;
    logic [4:0]       rd, rs1, rs2;
    logic             hazard, accept, issue;

    assign rd  = instr_i[11:7];
    assign rs1 = instr_i[19:15];
    assign rs2 = instr_i[24:20];

    // x0 has no scoreboard bit, so it can never be busy
    always_comb begin
        hazard = 1'b0;
        sb_eff = '0;
        for (int i = 1; i < NREGS; i++) begin
            sb_eff[i] = sb[i] & !(wb_vld_i && wb_rd_i == 5'(i));
            hazard = hazard | (sb_eff[i] & ((dec_rs1_vld_i && rs1 == 5'(i)) ||
                                            (dec_rs2_vld_i && rs2 == 5'(i)) ||
                                            (!ALLOW_WAW && dec_rd_vld_i && rd == 5'(i))));
        end
    end

    assign instr_rdy_o = (state == RUN) & (!iss_vld_o | iss_rdy_i) & !hazard & !flush_i;
    assign accept      = instr_vld_i & instr_rdy_o;
    assign issue       = accept & dec_vld_i & !dec_is_wfi_i;

    always_comb begin
        sb_n = '0;
        for (int i = 1; i < NREGS; i++)
            sb_n[i] = sb_eff[i] | (issue && dec_rd_vld_i && rd == 5'(i));
    end

    always_comb begin
        state_n = state;
        case (state)
            RUN:     if (accept) state_n = !dec_vld_i ? TRAP : dec_is_wfi_i ? WFI :
                                           (dec_is_branch_i | dec_is_jal_i) ? BR_WAIT : RUN;
            BR_WAIT: if (br_done_i) state_n = RUN;
            WFI:     if (irq_i) state_n = RUN;
            default: state_n = TRAP;
        endcase
        if (flush_i) state_n = RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= RUN;
            sb              <= '0;
            iss_vld_o       <= 1'b0;
            iss_instr_o     <= '0;
            iss_aluop_o     <= '0;
            iss_imm_o       <= '0;
            iss_rd_vld_o    <= 1'b0;
            iss_is_branch_o <= 1'b0;
            iss_is_jal_o    <= 1'b0;
            illegal_o       <= 1'b0;
        end else begin
            state     <= state_n;
            sb        <= sb_n;
            illegal_o <= accept & !dec_vld_i;
            iss_vld_o <= !flush_i & (issue | (iss_vld_o & !iss_rdy_i));
            if (issue) begin
                iss_instr_o     <= instr_i;
                iss_aluop_o     <= dec_aluop_i;
                iss_imm_o       <= dec_imm_i;
                iss_rd_vld_o    <= dec_rd_vld_i;
                iss_is_branch_o <= dec_is_branch_i;
                iss_is_jal_o    <= dec_is_jal_i;
            end
        end
    end

    assign state_o = state;
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: cycle-by-cycle vector table for issue_ctrl plus hand-written
// reset sequences; registered outputs checked #1 after the driving negedge.
module tb_issue_ctrl;
    logic        clk = 1'b0, rst_n;
    logic [31:0] instr;
    logic        instr_vld, instr_rdy;
    logic        dec_vld, dec_rd_vld, dec_rs1_vld, dec_rs2_vld, dec_br, dec_jal, dec_wfi;
    logic        wb_vld, br_done, flush, irq, iss_rdy;
    logic [4:0]  wb_rd;
    logic        iss_vld, iss_rd_vld, iss_br, iss_jal, illegal;
    logic [31:0] iss_instr;
    logic [3:0]  iss_aluop, iss_imm;
    logic [1:0]  state;

    issue_ctrl dut (
        .clk(clk), .rst_n(rst_n), .instr_i(instr), .instr_vld_i(instr_vld),
        .instr_rdy_o(instr_rdy), .dec_vld_i(dec_vld), .dec_rd_vld_i(dec_rd_vld),
        .dec_rs1_vld_i(dec_rs1_vld), .dec_rs2_vld_i(dec_rs2_vld),
        .dec_is_branch_i(dec_br), .dec_is_jal_i(dec_jal), .dec_is_wfi_i(dec_wfi),
        .dec_imm_i(instr[27:24]), .dec_aluop_i(instr[31:28]), .wb_vld_i(wb_vld),
        .wb_rd_i(wb_rd), .br_done_i(br_done), .flush_i(flush), .irq_i(irq),
        .iss_vld_o(iss_vld), .iss_rdy_i(iss_rdy), .iss_instr_o(iss_instr),
        .iss_aluop_o(iss_aluop), .iss_imm_o(iss_imm), .iss_rd_vld_o(iss_rd_vld),
        .iss_is_branch_o(iss_br), .iss_is_jal_o(iss_jal), .illegal_o(illegal),
        .state_o(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        vld;
        logic [31:0] ins;
        logic [6:0]  dec;
        logic [4:0]  ctl;
        logic [4:0]  wbrd;
        logic        e_rdy;
        logic        e_vld;
        logic [31:0] e_ins;
        logic [2:0]  e_dec;
        logic        e_ill;
        logic [1:0]  e_st;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0, n_err = 0;

    // dec = {dec_vld, rd_vld, rs1_vld, rs2_vld, branch, jal, wfi}
    localparam logic [6:0] D_ALU = 7'b1111000, D_BR = 7'b1011100, D_JAL = 7'b1100010,
                           D_WFI = 7'b1000001, D_ILL = 7'b0000000;
    // ctl = {wb_vld, br_done, flush, irq, iss_rdy}
    localparam logic [4:0] C_RDY = 5'b00001, C_WB = 5'b10001, C_BRD = 5'b01001,
                           C_FL = 5'b00101, C_IRQ = 5'b00011, C_STL = 5'b00000;
    localparam logic [2:0] E_ALU = 3'b100;

    function automatic logic [31:0] mk(input logic [4:0] rd, rs1, rs2, input logic [6:0] tag);
        return {tag, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    task automatic add(input logic vld, input logic [31:0] ins, input logic [6:0] dec,
                       input logic [4:0] ctl, input logic [4:0] wbrd, input logic e_rdy,
                       input logic e_vld, input logic [31:0] e_ins, input logic [2:0] e_dec,
                       input logic e_ill, input logic [1:0] e_st);
        vec_t v;
        v.vld = vld; v.ins = ins; v.dec = dec; v.ctl = ctl; v.wbrd = wbrd;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_ins = e_ins; v.e_dec = e_dec;
        v.e_ill = e_ill; v.e_st = e_st;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act, exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [31:0] ins, input logic [6:0] dec,
                         input logic [4:0] ctl, input logic [4:0] wbrd);
        instr_vld = vld; instr = ins;
        {dec_vld, dec_rd_vld, dec_rs1_vld, dec_rs2_vld, dec_br, dec_jal, dec_wfi} = dec;
        {wb_vld, br_done, flush, irq, iss_rdy} = ctl;
        wb_rd = wbrd;
    endtask

    initial begin
        // three independent ADDs, then RAW/WAW stalls and writeback bypass
        add(1, mk(1,0,0,1),   D_ALU, C_RDY, 0, 1, 0, 0, 0, 0, 0);
        add(1, mk(2,0,0,2),   D_ALU, C_RDY, 0, 1, 1, mk(1,0,0,1), E_ALU, 0, 0);
        add(1, mk(3,0,0,3),   D_ALU, C_RDY, 0, 1, 1, mk(2,0,0,2), E_ALU, 0, 0);
        add(0, 0,             0,     C_RDY, 0, 1, 1, mk(3,0,0,3), E_ALU, 0, 0);
        add(1, mk(4,1,0,4),   D_ALU, C_RDY, 0, 0, 0, 0, 0, 0, 0);
        add(1, mk(2,0,0,5),   D_ALU, C_RDY, 0, 0, 0, 0, 0, 0, 0);
        add(1, mk(4,0,3,6),   D_ALU, C_RDY, 0, 0, 0, 0, 0, 0, 0);
        add(1, mk(4,1,0,4),   D_ALU, C_WB,  1, 1, 0, 0, 0, 0, 0);
        add(0, 0,             0,     C_WB,  2, 1, 1, mk(4,1,0,4), E_ALU, 0, 0);
        add(0, 0,             0,     C_WB,  3, 1, 0, 0, 0, 0, 0);
        add(0, 0,             0,     C_WB,  4, 1, 0, 0, 0, 0, 0);
        add(1, mk(5,2,3,7),   D_ALU, C_RDY, 0, 1, 0, 0, 0, 0, 0);
        // execute back-pressure holds the slot
        add(1, mk(6,0,0,8),   D_ALU, C_STL, 0, 0, 1, mk(5,2,3,7), E_ALU, 0, 0);
        add(1, mk(6,0,0,8),   D_ALU, C_STL, 0, 0, 1, mk(5,2,3,7), E_ALU, 0, 0);
        add(1, mk(6,0,0,8),   D_ALU, C_STL, 0, 0, 1, mk(5,2,3,7), E_ALU, 0, 0);
        add(1, mk(6,0,0,8),   D_ALU, C_STL, 0, 0, 1, mk(5,2,3,7), E_ALU, 0, 0);
        add(1, mk(6,0,0,8),   D_ALU, C_RDY, 0, 1, 1, mk(5,2,3,7), E_ALU, 0, 0);
        add(0, 0,             0,     C_RDY, 0, 1, 1, mk(6,0,0,8), E_ALU, 0, 0);
        // set beats a same-cycle writeback to the same register
        add(1, mk(7,0,0,9),   D_ALU, C_WB,  7, 1, 0, 0, 0, 0, 0);
        add(1, mk(8,7,0,10),  D_ALU, C_RDY, 0, 0, 1, mk(7,0,0,9), E_ALU, 0, 0);
        add(1, mk(8,7,0,10),  D_ALU, C_WB,  7, 1, 0, 0, 0, 0, 0);
        add(0, 0,             0,     C_WB,  5, 1, 1, mk(8,7,0,10), E_ALU, 0, 0);
        add(0, 0,             0,     C_WB,  6, 1, 0, 0, 0, 0, 0);
        add(0, 0,             0,     C_WB,  8, 1, 0, 0, 0, 0, 0);
        // rd = x0 is never tracked
        add(1, mk(0,0,0,11),  D_ALU, C_RDY, 0, 1, 0, 0, 0, 0, 0);
        add(1, mk(9,0,0,12),  D_ALU, C_RDY, 0, 1, 1, mk(0,0,0,11), E_ALU, 0, 0);
        add(0, 0,             0,     C_WB,  9, 1, 1, mk(9,0,0,12), E_ALU, 0, 0);
        // branch; br_done with the accept is ignored
        add(1, mk(0,1,2,13),  D_BR,  C_BRD, 0, 1, 0, 0, 0, 0, 0);
        add(1, mk(10,0,0,14), D_ALU, C_RDY, 0, 0, 1, mk(0,1,2,13), 3'b010, 0, 1);
        add(1, mk(10,0,0,14), D_ALU, C_RDY, 0, 0, 0, 0, 0, 0, 1);
        add(1, mk(10,0,0,14), D_ALU, C_BRD, 0, 0, 0, 0, 0, 0, 1);
        add(1, mk(10,0,0,14), D_ALU, C_RDY, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0,             0,     C_RDY, 0, 1, 1, mk(10,0,0,14), E_ALU, 0, 0);
        // jal resolved while the slot is still back-pressured
        add(1, mk(11,0,0,15), D_JAL, C_RDY, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0,             0,     5'b01000, 0, 0, 1, mk(11,0,0,15), 3'b101, 0, 1);
        add(0, 0,             0,     C_RDY, 0, 1, 1, mk(11,0,0,15), 3'b101, 0, 0);
        add(0, 0,             0,     C_WB, 10, 1, 0, 0, 0, 0, 0);
        add(0, 0,             0,     C_WB, 11, 1, 0, 0, 0, 0, 0);
        // illegal opcode traps until flush
        add(1, 32'hFFFFFFFF,  D_ILL, C_RDY, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0,             0,     C_RDY, 0, 0, 0, 0, 0, 1, 3);
        add(1, mk(12,0,0,16), D_ALU, C_RDY, 0, 0, 0, 0, 0, 0, 3);
        add(1, mk(12,0,0,16), D_ALU, C_FL,  0, 0, 0, 0, 0, 0, 3);
        add(1, mk(12,0,0,16), D_ALU, C_RDY, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0,             0,     C_WB, 12, 1, 1, mk(12,0,0,16), E_ALU, 0, 0);
        // flush empties a stalled slot but keeps the scoreboard
        add(1, mk(13,0,0,17), D_ALU, C_STL, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0,             0,     5'b00100, 0, 0, 1, mk(13,0,0,17), E_ALU, 0, 0);
        add(0, 0,             0,     C_RDY, 0, 1, 0, 0, 0, 0, 0);
        add(1, mk(14,13,0,18), D_ALU, C_RDY, 0, 0, 0, 0, 0, 0, 0);
        add(1, mk(14,13,0,18), D_ALU, C_WB, 13, 1, 0, 0, 0, 0, 0);
        add(0, 0,             0,     C_WB, 14, 1, 1, mk(14,13,0,18), E_ALU, 0, 0);
        // WFI parks until irq; flush blocks a same-cycle accept
        add(1, 32'h10500073,  D_WFI, C_RDY, 0, 1, 0, 0, 0, 0, 0);
        add(1, mk(15,0,0,19), D_ALU, C_RDY, 0, 0, 0, 0, 0, 0, 2);
        add(1, mk(15,0,0,19), D_ALU, C_IRQ, 0, 0, 0, 0, 0, 0, 2);
        add(1, mk(15,0,0,19), D_ALU, C_RDY, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0,             0,     C_WB, 15, 1, 1, mk(15,0,0,19), E_ALU, 0, 0);
        add(1, mk(16,0,0,20), D_ALU, C_FL,  0, 0, 0, 0, 0, 0, 0);
        add(0, 0,             0,     C_RDY, 0, 1, 0, 0, 0, 0, 0);
        add(1, mk(16,0,0,20), D_ALU, C_RDY, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0,             0,     C_WB, 16, 1, 1, mk(16,0,0,20), E_ALU, 0, 0);

        rst_n = 1'b0;
        drive(1, mk(1,2,3,99), D_BR, 5'b11111, 5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, C_RDY, 0);
        #1;
        chk("reset_vld", -1, 32'(iss_vld), 0);
        chk("reset_instr", -1, iss_instr, 0);
        chk("reset_payload", -1, 32'({iss_aluop, iss_imm, iss_rd_vld, iss_br, iss_jal}), 0);
        chk("reset_illegal", -1, 32'(illegal), 0);
        chk("reset_state", -1, 32'(state), 0);

        foreach (tbl[r]) begin
            @(negedge clk);
            drive(tbl[r].vld, tbl[r].ins, tbl[r].dec, tbl[r].ctl, tbl[r].wbrd);
            #1;
            chk("instr_rdy", r, 32'(instr_rdy), 32'(tbl[r].e_rdy));
            chk("iss_vld", r, 32'(iss_vld), 32'(tbl[r].e_vld));
            chk("illegal", r, 32'(illegal), 32'(tbl[r].e_ill));
            chk("state", r, 32'(state), 32'(tbl[r].e_st));
            if (tbl[r].e_vld) begin
                chk("iss_instr", r, iss_instr, tbl[r].e_ins);
                chk("iss_aluop", r, 32'(iss_aluop), 32'(tbl[r].e_ins[31:28]));
                chk("iss_imm", r, 32'(iss_imm), 32'(tbl[r].e_ins[27:24]));
                chk("iss_flags", r, 32'({iss_rd_vld, iss_br, iss_jal}), 32'(tbl[r].e_dec));
            end
        end

        // reset mid-operation drops the slot and the pending x17 write
        @(negedge clk);
        drive(1, mk(17,0,0,21), D_ALU, C_STL, 0);
        @(negedge clk);
        rst_n = 1'b0;
        drive(0, 0, 0, C_STL, 0);
        #1;
        chk("pre_reset_vld", -2, 32'(iss_vld), 1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, mk(18,17,0,22), D_ALU, C_RDY, 0);
        #1;
        chk("midreset_vld", -2, 32'(iss_vld), 0);
        chk("midreset_instr", -2, iss_instr, 0);
        chk("midreset_sb", -2, 32'(instr_rdy), 1);
        @(negedge clk);
        drive(0, 0, 0, C_RDY, 0);
        #1;
        chk("post_reset_issue", -2, iss_instr, mk(18,17,0,22));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
Single-issue decode/issue sequencer between instruction fetch and the execute stage. It takes a fetched instruction plus the combinational decode fields from the instruction decoder and holds them in a registered issue slot with a valid/ready handshake. It tracks pending register writes in a scoreboard and stalls on RAW/WAW hazards. It serialises control flow: stops after branch/jal until resolution, parks on WFI, and traps on illegal opcodes.

Parameters:
NREGS, 32, number of architectural registers tracked in the scoreboard; x0 is never tracked.
ALLOW_WAW, 0, 0 = stall when a pending write targets the same rd; 1 = ignore the rd check.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
instr_i  in  32  fetched instruction; rd=[11:7], rs1=[19:15], rs2=[24:20]
instr_vld_i  in  1  fetch has a valid instruction
instr_rdy_o  out  1  instruction accepted this cycle when instr_vld_i is also high
dec_vld_i, dec_rd_vld_i, dec_rs1_vld_i, dec_rs2_vld_i  in  1 each  decoder outputs for instr_i
dec_is_branch_i, dec_is_jal_i, dec_is_wfi_i  in  1 each  decoder outputs for instr_i
dec_imm_i  in  4  decoder immediate format
dec_aluop_i  in  4  decoder ALU operation
wb_vld_i  in  1  writeback retiring a register write
wb_rd_i  in  5  writeback destination register
br_done_i  in  1  execute has resolved the outstanding branch/jal
flush_i  in  1  pipeline flush (redirect/trap exit)
irq_i  in  1  wake request (level)
iss_vld_o  out  1  issue slot valid
iss_rdy_i  in  1  execute accepts the slot
iss_instr_o  out  32  issued instruction
iss_aluop_o  out  4  issued ALU operation
iss_imm_o  out  4  issued immediate format
iss_rd_vld_o  out  1  issued instruction writes rd
iss_is_branch_o  out  1  issued instruction is a branch
iss_is_jal_o  out  1  issued instruction is a jal
illegal_o  out  1  one-cycle pulse on an illegal opcode
state_o  out  2  0=RUN 1=BR_WAIT 2=WFI 3=TRAP

Behaviour:
- Reset (rst_n low at a clk edge):
  - State = RUN; scoreboard all 0.
  - iss_vld_o = 0 and every iss_* payload = 0; illegal_o = 0.
  - Reset mid-operation discards the slot and all pending state.
- Scoreboard effective view (same cycle):
  - sb_eff = sb with bit wb_rd_i cleared when wb_vld_i is high (writeback bypass).
- Hazard, using instr_i fields:
  - (dec_rs1_vld_i & sb_eff[rs1]) | (dec_rs2_vld_i & sb_eff[rs2]) | (!ALLOW_WAW & dec_rd_vld_i & sb_eff[rd]).
  - Index 0 is never busy.
- Slot free: !iss_vld_o | iss_rdy_i.
- instr_rdy_o = (state==RUN) & slot free & !hazard & !flush_i. It is combinational and must not depend on instr_vld_i.
- Accept (instr_vld_i & instr_rdy_o), priority order:
  - !dec_vld_i:
    - Nothing issued; scoreboard unchanged.
    - illegal_o = 1 next cycle for exactly one cycle.
    - State -> TRAP.
  - dec_is_wfi_i: instruction consumed, nothing issued, state -> WFI.
  - Otherwise:
    - Next cycle iss_vld_o = 1 with the payload captured.
    - If dec_rd_vld_i and rd != 0, set sb[rd]; a set wins over a same-cycle wb clear to the same index.
    - If dec_is_branch_i | dec_is_jal_i, state -> BR_WAIT.
- Slot handshake:
  - Slot held stable while iss_vld_o & !iss_rdy_i.
  - On iss_rdy_i with no new accept, iss_vld_o -> 0.
  - Back-to-back issue gives 1 instruction/cycle when there are no hazards.
  - Latency from accept to iss_vld_o is 1 cycle.
- Writeback: wb_vld_i clears sb[wb_rd_i] at the clk edge. wb_rd_i = 0 is ignored. Writebacks are honoured in every state, including during flush.
- BR_WAIT:
  - No accepts; the already-captured branch still drains via the handshake.
  - br_done_i -> RUN next cycle.
  - br_done_i in the same cycle as the branch accept is ignored; execute cannot resolve an unissued branch.
- WFI: no accepts; irq_i -> RUN next cycle.
- TRAP: no accepts; exits only through flush_i.
- flush_i (any state, highest priority):
  - Next cycle iss_vld_o = 0 and state = RUN.
  - No accept in the flush cycle.
  - Scoreboard is not cleared, because in-flight writes still retire.
  - illegal_o is unaffected once pulsed.
- state_o reflects the registered state.

Test Plan:
- Reset then three independent ADDs (rd 1,2,3; no sources pending), iss_rdy_i=1 -> iss_vld_o high 3 consecutive cycles starting 1 cycle after first accept; sb bits 1-3 set.
- ADD x5 issued, then SUB x6,x5,x7 presented -> instr_rdy_o=0 until wb_vld_i=1, wb_rd_i=5; SUB accepted in that same wb cycle (bypass).
- iss_rdy_i=0 for 4 cycles with slot full -> iss_* payload stable, instr_rdy_o=0; rdy high -> next instruction issued the following cycle.
- BEQ accepted -> state_o=1, further instr_vld_i ignored; br_done_i pulse -> state_o=0 next cycle, accepts resume.
- Opcode 0xFFFFFFFF (dec_vld_i=0) -> illegal_o high exactly 1 cycle, state_o=3, no issue; flush_i -> state_o=0, iss_vld_o=0.
- WFI accepted -> state_o=2, no issue; irq_i=1 -> state_o=0; flush_i together with a valid hazard-free instruction -> instruction not accepted that cycle.
